debug_page_sched: RTL and testbench
===================================

// Module: debug_page_sched
// PURPOSE
//  Sequencer feeding the on-screen hex debug overlay's single 64-bit debug input.
//  Selects one of NUM_SRC 64-bit probe words (page) and snapshots it only on vblank rise: stable per frame, no tearing.
//  Page select by user button or auto-rotation; freeze hold; optional capture-on-match trigger.
//  Sits between core debug taps and the overlay renderer, in the video clock domain.
// PARAMETERS
//  NUM_SRC      4      number of 64-bit probe sources, 2..16
//  AUTO_FRAMES  0      frames per page in auto-rotate; 0 = auto-rotate off
//  DEB_CYCLES   65536  cycles i_next must be stable before it is accepted
// PORTS
//  clk          in   1           video/pixel clock
//  i_reset      in   1           asynchronous, active-high reset
//  i_vblank     in   1           vertical blank, synchronous to clk
//  i_probes     in   NUM_SRC*64  packed probe words; source n = [n*64+63:n*64]
//  i_next       in   1           page-advance button, asynchronous (2-flop synced inside)
//  i_freeze     in   1           level: hold current snapshot
//  o_debug      out  64          snapshot word to overlay
//  o_page       out  PAGE_W      current page, PAGE_W = clog2(NUM_SRC)
//  o_valid      out  1           a snapshot has been taken since reset
// BEHAVIOUR
//  Reset: o_debug=0, o_page=0, o_valid=0, frame counter=0, state=RUN, sync/debounce regs cleared.
//  Reset applies immediately mid-frame; first capture comes at the first vblank rise after release.
//  vblank edge: vb_d registered; vb_rise = i_vblank & ~vb_d.
//  i_next: sync -> debounce (stable DEB_CYCLES) -> rising edge = one next_req pulse per press.
//  Page advance: page <= (page==NUM_SRC-1) ? 0 : page+1; o_page updates the cycle after the request.
//  Auto: frame counter increments on vb_rise. At AUTO_FRAMES-1 it wraps to 0 and advances the page.
//  Manual next_req clears the frame counter.
//  next_req and auto advance in the same cycle: a single +1 only.
//  Capture: on vb_rise in RUN, o_debug <= probe[page]; o_valid <= 1.
//  Latency: o_debug changes 2 clk after i_vblank rises.
//  A page change in the vb_rise cycle: the capture uses the OLD page; the new page shows next frame.
//  States:
//   RUN  : capture on every vb_rise; i_freeze=1 -> HOLD.
//   HOLD : o_debug frozen; next_req and auto advance ignored; frame counter stalled; i_freeze=0 -> RUN.
//  i_freeze is sampled each clk; a freeze asserted in the vb_rise cycle blocks that capture.
// CONFIGURATION
//  Macro DEBUG_TRIGGER_EN adds:
//   Ports: i_trig_mask[63:0] in, i_trig_value[63:0] in, i_arm in (pulse), o_trig out (reset 0).
//   States ARMED and TRIG.
//   RUN, i_arm=1 -> ARMED: behaves as RUN; additionally, any clk with (probe[page] & mask) == value:
//    o_debug <= probe[page], o_valid <= 1, o_trig <= 1, -> TRIG, ignoring vblank.
//   TRIG: o_debug held, page held.
//   TRIG, next_req -> RUN: o_trig <= 0, no page advance on that press.
//   i_freeze has priority over both: ARMED/TRIG -> HOLD on freeze; HOLD returns to RUN (disarmed, o_trig <= 0).
//   Match and vb_rise in the same cycle: the match capture wins; same value, since both use probe[page].
//  Without the macro: no extra ports; states RUN/HOLD only.
// STRUCTURE
//  analyzer_pkg (shared `include):
//   state encodings RUN=0, HOLD=1, ARMED=2, TRIG=3;
//   PAGE_W clog2 function; overlay width constant DBG_W=64.
//  Sub-module input_debounce (sync + DEB_CYCLES counter + edge pulse); reusable for other buttons.
//  Probe mux, frame counter and FSM live in this module.
// TESTING
//  1. NUM_SRC=4, probes 0x1111..,0x2222..,0x3333..,0x4444.., vblank pulses
//     -> o_debug=0x1111.. 2 clk after the first rise; o_valid=1.
//  2. Four debounced i_next presses
//     -> o_page 1,2,3,0; each new word appears only at the following vblank rise.
//  3. Bounce i_next shorter than DEB_CYCLES
//     -> no page change; a clean press held DEB_CYCLES -> exactly one advance.
//  4. AUTO_FRAMES=3 -> page advances every 3rd vblank.
//     Press i_next in the same cycle as an auto advance -> page +1 only, counter cleared.
//  5. i_freeze=1 with probes changing and presses issued -> o_debug and o_page constant.
//     Release -> capture resumes at the next vblank.
//  6. DEBUG_TRIGGER_EN, mask=0xFF, value=0x5A, arm; probe[page] low byte hits 0x5A mid-frame
//     -> o_debug = that word next clk, o_trig=1, held until next press.
//     Assert i_reset mid-hold -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/analyzer_pkg.sv
// Shared definitions for the debug overlay page sequencer: overlay word width,
// FSM state encodings and the page-index width helper.
package analyzer_pkg;

    localparam int DBG_W = 64;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ARMED = 2'd2,
        ST_TRIG  = 2'd3
    } state_t;

    // Page index width; a two-source build still needs one bit.
    function automatic int page_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/input_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter and a single-cycle
// pulse on each accepted rising edge. Reusable for any asynchronous push button.
module input_debounce #(
    parameter int DEB_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic press
);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [1:0]       sync;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             settled;

    assign settled = (cnt == CNT_W'(DEB_CYCLES - 1));

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // so sync[1] below is last cycle's value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], button};
            press <= 1'b0;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (settled) begin
                stable <= sync[1];
                cnt    <= '0;
                press  <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/debug_page_sched.sv
// Page sequencer for the hex debug overlay: per-frame snapshot of one probe word,
// manual/auto paging and freeze. Optional capture-on-match via DEBUG_TRIGGER_EN.
module debug_page_sched
    import analyzer_pkg::*;
#(
    parameter int  NUM_SRC     = 4,
    parameter int  AUTO_FRAMES = 0,
    parameter int  DEB_CYCLES  = 65536,
    localparam int PAGE_W      = page_w(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic                     i_vblank,
    input  logic [NUM_SRC*DBG_W-1:0] i_probes,
    input  logic                     i_next,
    input  logic                     i_freeze,
`ifdef DEBUG_TRIGGER_EN
    input  logic [DBG_W-1:0]         i_trig_mask,
    input  logic [DBG_W-1:0]         i_trig_value,
    input  logic                     i_arm,
    output logic                     o_trig,
`endif
    output logic [DBG_W-1:0]         o_debug,
    output logic [PAGE_W-1:0]        o_page,
    output logic                     o_valid
);
    localparam bit                AUTO_ON   = (AUTO_FRAMES > 0);
    localparam int                FC_W      = (AUTO_FRAMES > 2) ? $clog2(AUTO_FRAMES) : 1;
    localparam int                FC_LAST   = AUTO_ON ? AUTO_FRAMES - 1 : 0;
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_SRC - 1);

    state_t            state, state_nx;
    logic              vb_d, vb_rise_q, next_req;
    logic [PAGE_W-1:0] page;
    logic [FC_W-1:0]   frame_cnt;
    logic [DBG_W-1:0]  probe_sel;
    logic              adv_en, cap_en, trig_cap;
    logic              auto_hit, do_adv, do_cap;
`ifdef DEBUG_TRIGGER_EN
    logic              trig_clr, match;
`endif

    input_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_next_deb (
        .clk    (clk),
        .rst    (i_reset),
        .button (i_next),
        .press  (next_req)
    );

    assign probe_sel = i_probes[int'(page)*DBG_W +: DBG_W];
`ifdef DEBUG_TRIGGER_EN
    assign match = ((probe_sel & i_trig_mask) == i_trig_value);
`endif

    // The rise strobe is registered so capture lands two clocks after vblank rises.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            vb_d      <= 1'b0;
            vb_rise_q <= 1'b0;
            state     <= ST_RUN;
        end else begin
            vb_d      <= i_vblank;
            vb_rise_q <= i_vblank & ~vb_d;
            state     <= state_nx;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        adv_en   = 1'b0;
        cap_en   = 1'b0;
        trig_cap = 1'b0;
`ifdef DEBUG_TRIGGER_EN
        trig_clr = 1'b0;
`endif
        case (state)
            ST_RUN: begin
                if (i_freeze) begin
                    state_nx = ST_HOLD;
                end else begin
                    adv_en = 1'b1;
                    cap_en = 1'b1;
`ifdef DEBUG_TRIGGER_EN
                    if (i_arm) state_nx = ST_ARMED;
`endif
                end
            end
            ST_HOLD: begin
                if (!i_freeze) begin
                    state_nx = ST_RUN;
`ifdef DEBUG_TRIGGER_EN
                    trig_clr = 1'b1;
`endif
                end
            end
`ifdef DEBUG_TRIGGER_EN
            ST_ARMED: begin
                if (i_freeze) begin
                    state_nx = ST_HOLD;
                end else if (match) begin
                    // Match beats a coincident vblank capture; both would load probe_sel.
                    trig_cap = 1'b1;
                    state_nx = ST_TRIG;
                end else begin
                    adv_en = 1'b1;
                    cap_en = 1'b1;
                end
            end
            ST_TRIG: begin
                if (i_freeze) begin
                    state_nx = ST_HOLD;
                end else if (next_req) begin
                    state_nx = ST_RUN;
                    trig_clr = 1'b1;
                end
            end
`endif
            default: state_nx = ST_RUN;
        endcase
    end

    assign auto_hit = AUTO_ON && vb_rise_q && (frame_cnt == FC_W'(FC_LAST));
    assign do_adv   = adv_en && (next_req || auto_hit);
    assign do_cap   = (cap_en && vb_rise_q) || trig_cap;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            frame_cnt <= '0;
            page      <= '0;
            o_debug   <= '0;
            o_valid   <= 1'b0;
        end else begin
            if (adv_en && next_req) begin
                frame_cnt <= '0;
            end else if (AUTO_ON && adv_en && vb_rise_q) begin
                frame_cnt <= auto_hit ? '0 : frame_cnt + 1'b1;
            end
            // Manual and auto requests in one cycle collapse into a single step.
            if (do_adv) begin
                page <= (page == PAGE_LAST) ? '0 : page + 1'b1;
            end
            if (do_cap) begin
                o_debug <= probe_sel;
                o_valid <= 1'b1;
            end
        end
    end

`ifdef DEBUG_TRIGGER_EN
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            o_trig <= 1'b0;
        end else if (trig_cap) begin
            o_trig <= 1'b1;
        end else if (trig_clr) begin
            o_trig <= 1'b0;
        end
    end
`endif

    assign o_page = page;

endmodule

// File: tb/tb_debug_page_sched.sv
// Directed bench for debug_page_sched: two instances (auto-rotate off and every 3
// frames) share stimulus. Trigger scenario compiles in when DEBUG_TRIGGER_EN is set.
module tb_debug_page_sched;

    localparam int DEB = 8;
    localparam logic [63:0] P0 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] P1 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] P2 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] P3 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] PX = 64'h0F0F_A5A5_0F0F_A5A5;
    localparam logic [63:0] PW [4] = '{P0, P1, P2, P3};

    logic         clk = 1'b0;
    logic         i_reset, i_vblank, i_next, i_freeze;
    logic [63:0]  probe [4];
    logic [255:0] probes;
    logic [63:0]  dbg0, dbg1;
    logic [1:0]   page0, page1;
    logic         valid0, valid1;
`ifdef DEBUG_TRIGGER_EN
    logic [63:0]  mask, value;
    logic         arm, trig0, trig1;
`endif

    int checks   = 0;
    int failures = 0;

    assign probes = {probe[3], probe[2], probe[1], probe[0]};

    always #5 clk = ~clk;

    debug_page_sched #(.NUM_SRC(4), .AUTO_FRAMES(0), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .i_reset(i_reset), .i_vblank(i_vblank), .i_probes(probes),
        .i_next(i_next), .i_freeze(i_freeze),
`ifdef DEBUG_TRIGGER_EN
        .i_trig_mask(mask), .i_trig_value(value), .i_arm(arm), .o_trig(trig0),
`endif
        .o_debug(dbg0), .o_page(page0), .o_valid(valid0)
    );

    debug_page_sched #(.NUM_SRC(4), .AUTO_FRAMES(3), .DEB_CYCLES(DEB)) dut_auto (
        .clk(clk), .i_reset(i_reset), .i_vblank(i_vblank), .i_probes(probes),
        .i_next(i_next), .i_freeze(i_freeze),
`ifdef DEBUG_TRIGGER_EN
        .i_trig_mask(mask), .i_trig_value(value), .i_arm(arm), .o_trig(trig1),
`endif
        .o_debug(dbg1), .o_page(page1), .o_valid(valid1)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_probes();
        for (int i = 0; i < 4; i++) probe[i] = PW[i];
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_vblank = 1'b0; i_next = 1'b0; i_freeze = 1'b0;
`ifdef DEBUG_TRIGGER_EN
        arm = 1'b0;
`endif
        load_probes();
        tick(2);
        i_reset = 1'b0;
        tick(2);
    endtask

    task automatic frame();
        i_vblank = 1'b1; tick(4);
        i_vblank = 1'b0; tick(4);
    endtask

    task automatic press();
        i_next = 1'b1; tick(DEB + 6);
        i_next = 1'b0; tick(DEB + 6);
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_vblank = 1'b0; i_next = 1'b0; i_freeze = 1'b0;
`ifdef DEBUG_TRIGGER_EN
        arm = 1'b0; mask = 64'hFF; value = 64'h5A;
`endif
        load_probes();
        tick(2);
        checks++; if (dbg0 !== 64'd0 || dbg1 !== 64'd0) begin failures++; $display("FAIL reset_debug: got %h/%h want 0", dbg0, dbg1); end
        checks++; if (page0 !== 2'd0 || valid0 !== 1'b0) begin failures++; $display("FAIL reset_page_valid: page %0d valid %b want 0 0", page0, valid0); end
        i_reset = 1'b0;
        tick(2);
        press();
        frame();
        checks++; if (dbg0 !== P1 || page0 !== 2'd1) begin failures++; $display("FAIL pre_async_reset: debug %h page %0d want %h 1", dbg0, page0, P1); end
        // Reset asserted between edges must clear outputs without a clock edge.
        #2 i_reset = 1'b1;
        #1;
        checks++; if (dbg0 !== 64'd0 || page0 !== 2'd0 || valid0 !== 1'b0) begin failures++; $display("FAIL async_reset: debug %h page %0d valid %b want 0 0 0", dbg0, page0, valid0); end
        tick(1);
        i_reset = 1'b0;
        tick(2);
    endtask

    task automatic test_capture();
        do_reset();
        checks++; if (valid0 !== 1'b0) begin failures++; $display("FAIL valid_before_vblank: got %b want 0", valid0); end
        i_vblank = 1'b1;
        tick(1);
        checks++; if (dbg0 !== 64'd0 || valid0 !== 1'b0) begin failures++; $display("FAIL capture_latency1: debug %h valid %b want 0 0", dbg0, valid0); end
        tick(1);
        checks++; if (dbg0 !== P0 || valid0 !== 1'b1) begin failures++; $display("FAIL capture_latency2: debug %h valid %b want %h 1", dbg0, valid0, P0); end
        tick(3); i_vblank = 1'b0; tick(4);
        probe[0] = PX;
        tick(5);
        checks++; if (dbg0 !== P0) begin failures++; $display("FAIL stable_in_frame: got %h want %h", dbg0, P0); end
        probe[0] = P0;
    endtask

    task automatic test_manual_pages();
        do_reset();
        frame();
        for (int k = 1; k <= 4; k++) begin
            press();
            checks++; if (page0 !== 2'(k % 4)) begin failures++; $display("FAIL press_page%0d: got %0d want %0d", k, page0, k % 4); end
            checks++; if (dbg0 !== PW[(k - 1) % 4]) begin failures++; $display("FAIL press_hold%0d: got %h want %h", k, dbg0, PW[(k - 1) % 4]); end
            frame();
            checks++; if (dbg0 !== PW[k % 4]) begin failures++; $display("FAIL press_word%0d: got %h want %h", k, dbg0, PW[k % 4]); end
        end
    endtask

    task automatic test_page_change_at_capture();
        // Page is 0 here; the request pulse lands in the same cycle as the capture strobe.
        probe[0] = PX;
        i_next = 1'b1;
        tick(DEB + 1);
        i_vblank = 1'b1;
        tick(2);
        checks++; if (dbg0 !== PX || page0 !== 2'd1) begin failures++; $display("FAIL same_cycle_old_page: debug %h page %0d want %h 1", dbg0, page0, PX); end
        tick(2); i_vblank = 1'b0; i_next = 1'b0;
        tick(DEB + 6);
        frame();
        checks++; if (dbg0 !== P1) begin failures++; $display("FAIL same_cycle_next_frame: got %h want %h", dbg0, P1); end
        probe[0] = P0;
    endtask

    task automatic test_bounce();
        do_reset();
        for (int b = 0; b < 3; b++) begin
            i_next = 1'b1; tick(DEB - 2);
            i_next = 1'b0; tick(3);
        end
        tick(DEB + 4);
        checks++; if (page0 !== 2'd0) begin failures++; $display("FAIL bounce_ignored: page %0d want 0", page0); end
        i_next = 1'b1;
        tick(3 * DEB);
        checks++; if (page0 !== 2'd1) begin failures++; $display("FAIL clean_press: page %0d want 1", page0); end
        i_next = 1'b0;
        tick(DEB + 6);
        checks++; if (page0 !== 2'd1) begin failures++; $display("FAIL single_advance: page %0d want 1", page0); end
    endtask

    task automatic test_auto();
        logic [1:0] exp_page [8];
        exp_page = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
        do_reset();
        for (int f = 0; f < 8; f++) begin
            frame();
            checks++; if (page1 !== exp_page[f]) begin failures++; $display("FAIL auto_frame%0d: page %0d want %0d", f + 1, page1, exp_page[f]); end
            if (f == 2) begin
                checks++; if (dbg1 !== P0) begin failures++; $display("FAIL auto_old_word: got %h want %h", dbg1, P0); end
            end
        end
        // Third frame on page 2 would auto-advance; a press lands in that same cycle.
        i_next = 1'b1;
        tick(DEB + 1);
        i_vblank = 1'b1;
        tick(2);
        checks++; if (page1 !== 2'd3 || dbg1 !== P2) begin failures++; $display("FAIL auto_plus_press: page %0d debug %h want 3 %h", page1, dbg1, P2); end
        tick(2); i_vblank = 1'b0; i_next = 1'b0;
        tick(DEB + 6);
        frame();
        press();
        checks++; if (page1 !== 2'd0) begin failures++; $display("FAIL auto_manual: page %0d want 0", page1); end
        frame();
        frame();
        checks++; if (page1 !== 2'd0) begin failures++; $display("FAIL auto_count_cleared: page %0d want 0", page1); end
        frame();
        checks++; if (page1 !== 2'd1) begin failures++; $display("FAIL auto_after_clear: page %0d want 1", page1); end
    endtask

    task automatic test_freeze();
        do_reset();
        frame();
        i_freeze = 1'b1;
        tick(2);
        probe[0] = PX;
        press();
        frame();
        checks++; if (dbg0 !== P0 || page0 !== 2'd0) begin failures++; $display("FAIL freeze_hold: debug %h page %0d want %h 0", dbg0, page0, P0); end
        i_freeze = 1'b0;
        tick(2);
        checks++; if (dbg0 !== P0) begin failures++; $display("FAIL unfreeze_wait: got %h want %h", dbg0, P0); end
        frame();
        checks++; if (dbg0 !== PX) begin failures++; $display("FAIL unfreeze_capture: got %h want %h", dbg0, PX); end
        probe[0] = P0;
        i_vblank = 1'b1;
        tick(1);
        i_freeze = 1'b1;
        tick(1);
        checks++; if (dbg0 !== PX) begin failures++; $display("FAIL freeze_in_rise: got %h want %h", dbg0, PX); end
        tick(2); i_vblank = 1'b0; i_freeze = 1'b0;
        tick(4);
        frame();
        checks++; if (dbg0 !== P0) begin failures++; $display("FAIL freeze_resume: got %h want %h", dbg0, P0); end
    endtask

`ifdef DEBUG_TRIGGER_EN
    task automatic test_trigger();
        localparam logic [63:0] PT = 64'hDEAD_BEEF_CAFE_125A;
        do_reset();
        mask = 64'hFF; value = 64'h5A;
        frame();
        arm = 1'b1; tick(1); arm = 1'b0;
        checks++; if (trig0 !== 1'b0) begin failures++; $display("FAIL armed_no_trig: got %b want 0", trig0); end
        tick(3);
        probe[0] = PT;
        tick(1);
        checks++; if (dbg0 !== PT || trig0 !== 1'b1) begin failures++; $display("FAIL trig_capture: debug %h trig %b want %h 1", dbg0, trig0, PT); end
        probe[0] = P0;
        frame();
        checks++; if (dbg0 !== PT || page0 !== 2'd0) begin failures++; $display("FAIL trig_hold: debug %h page %0d want %h 0", dbg0, page0, PT); end
        press();
        checks++; if (trig0 !== 1'b0 || page0 !== 2'd0) begin failures++; $display("FAIL trig_release: trig %b page %0d want 0 0", trig0, page0); end
        frame();
        checks++; if (dbg0 !== P0) begin failures++; $display("FAIL trig_run_again: got %h want %h", dbg0, P0); end
        arm = 1'b1; tick(1); arm = 1'b0;
        probe[0] = PT;
        tick(1);
        checks++; if (trig0 !== 1'b1) begin failures++; $display("FAIL retrig: got %b want 1", trig0); end
        i_freeze = 1'b1;
        tick(2);
        #2 i_reset = 1'b1;
        #1;
        checks++; if (dbg0 !== 64'd0 || trig0 !== 1'b0 || valid0 !== 1'b0) begin failures++; $display("FAIL trig_async_reset: debug %h trig %b valid %b want 0 0 0", dbg0, trig0, valid0); end
        tick(1);
        i_reset = 1'b0; i_freeze = 1'b0;
        probe[0] = P0;
        tick(2);
    endtask
`endif

    initial begin
        test_reset();
        test_capture();
        test_manual_pages();
        test_page_change_at_capture();
        test_bounce();
        test_auto();
        test_freeze();
`ifdef DEBUG_TRIGGER_EN
        test_trigger();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
